// File: rtl/mips_pipe_pkg.sv
// Field layout of the EX/MEM and MEM/WB pipeline words and the store-data
// forwarding select codes shared by the MEM stage.
package mips_pipe_pkg;

    localparam int EX_MEM_W     = 75;
    localparam int MEM_WB_W     = 71;
    localparam int WORD_W       = 32;
    localparam int REG_W        = 5;

    localparam int EXM_ALU_LSB  = 0;
    localparam int EXM_DATA_LSB = 32;
    localparam int EXM_WR_LSB   = 64;
    localparam int EXM_MEMREAD  = 71;
    localparam int EXM_MEMTOREG = 72;
    localparam int EXM_MEMWRITE = 73;
    localparam int EXM_REGWRITE = 74;

    localparam int WB_RD_LSB    = 0;
    localparam int WB_WR_LSB    = 32;
    localparam int WB_REGWRITE  = 37;
    localparam int WB_ALU_LSB   = 38;
    localparam int WB_MEMTOREG  = 70;

    typedef enum logic [1:0] {
        FWD_EX     = 2'b00,
        FWD_WB_MEM = 2'b01,
        FWD_WB_ALU = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/mips_data_mem.sv
// Word-addressed data memory: combinational read gated by the read enable,
// synchronous write that is suppressed while reset is held.
module mips_data_mem #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              re_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    assign rdata_o = re_i ? mem_q[addr_i] : '0;

    // Array is not reset; a same-cycle read sees the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (we_i && rst_ni) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/mips_mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory access, MEM-to-MEM
// store-data forwarding from the WB instruction, and the MEM/WB register.
module mips_mem_stage
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [EX_MEM_W-1:0] ex_mem_reg,
    output logic [MEM_WB_W-1:0] mem_wb_reg
);

    logic [DATA_W-1:0]   exAlu;
    logic [DATA_W-1:0]   exData;
    logic [REG_W-1:0]    exWr;
    logic                exMemRead;
    logic                exMemToReg;
    logic                exMemWrite;
    logic                exRegWrite;
    logic [1:0]          unused_bits;

    logic [DATA_W-1:0]   wbRd;
    logic [DATA_W-1:0]   wbAlu;
    logic [REG_W-1:0]    wbWr;
    logic                wbRegWrite;
    logic                wbMemToReg;

    fwd_sel_e            fwdSel;
    logic [DATA_W-1:0]   selData;
    logic [DATA_W-1:0]   rdData;
    logic [MEM_WB_W-1:0] mem_wb_d;
    logic [MEM_WB_W-1:0] mem_wb_q;

    assign exAlu       = ex_mem_reg[EXM_ALU_LSB  +: WORD_W];
    assign exData      = ex_mem_reg[EXM_DATA_LSB +: WORD_W];
    assign exWr        = ex_mem_reg[EXM_WR_LSB   +: REG_W];
    assign exMemRead   = ex_mem_reg[EXM_MEMREAD];
    assign exMemToReg  = ex_mem_reg[EXM_MEMTOREG];
    assign exMemWrite  = ex_mem_reg[EXM_MEMWRITE];
    assign exRegWrite  = ex_mem_reg[EXM_REGWRITE];
    assign unused_bits = ex_mem_reg[70:69];

    assign wbRd        = mem_wb_q[WB_RD_LSB  +: WORD_W];
    assign wbWr        = mem_wb_q[WB_WR_LSB  +: REG_W];
    assign wbRegWrite  = mem_wb_q[WB_REGWRITE];
    assign wbAlu       = mem_wb_q[WB_ALU_LSB +: WORD_W];
    assign wbMemToReg  = mem_wb_q[WB_MEMTOREG];

    // A store whose data register is being written by the WB instruction
    // takes the value WB is about to commit instead of the stale EX copy.
    always_comb begin
        fwdSel = FWD_EX;
        if (exMemWrite && wbRegWrite && (wbWr != '0) && (wbWr == exWr)) begin
            fwdSel = wbMemToReg ? FWD_WB_MEM : FWD_WB_ALU;
        end
    end

    always_comb begin
        selData = exData;
        case (fwdSel)
            FWD_WB_MEM: selData = wbRd;
            FWD_WB_ALU: selData = wbAlu;
            default:    selData = exData;
        endcase
    end

    mips_data_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_data_mem (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .re_i    (exMemRead),
        .we_i    (exMemWrite),
        .addr_i  (exAlu[ADDR_W-1:0]),
        .wdata_i (selData),
        .rdata_o (rdData)
    );

    assign mem_wb_d = {exMemToReg, exAlu, exRegWrite, exWr, rdData};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    assign mem_wb_reg = mem_wb_q;

endmodule

// File: tb/tb_mips_mem_stage.sv
// Directed bench for the MEM stage: reset, forwarding paths, aliasing and
// read-during-write, checked against hand-computed MEM/WB words.
module tb_mips_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [74:0] ex_mem_reg;
    logic [70:0] mem_wb_reg;

    int vecCount  = 0;
    int missCount = 0;

    mips_mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_mem_reg (ex_mem_reg),
        .mem_wb_reg (mem_wb_reg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [74:0] exWord(input logic rw, input logic mw,
                                           input logic mtr, input logic mr,
                                           input logic [4:0] wr,
                                           input logic [31:0] data,
                                           input logic [31:0] alu);
        return {rw, mw, mtr, mr, 2'b00, wr, data, alu};
    endfunction

    function automatic logic [70:0] wbWord(input logic mtr, input logic [31:0] alu,
                                           input logic rw, input logic [4:0] wr,
                                           input logic [31:0] rd);
        return {mtr, alu, rw, wr, rd};
    endfunction

    task automatic applyStimulus(input logic [74:0] ex);
        ex_mem_reg = ex;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [70:0] expected);
        vecCount++;
        assert (mem_wb_reg === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, mem_wb_reg, expected);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        ex_mem_reg = '0;
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_init", '0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(exWord(1, 0, 0, 0, 5'd28, 32'h8f3da232, 32'h08438433));
        checkOutput("add", wbWord(0, 32'h08438433, 1, 5'd28, 32'h0));

        // fwd=10: stores the WB alu result 08438433 at word 0x19
        applyStimulus(exWord(0, 1, 0, 0, 5'd28, 32'h01354440, 32'h00000019));
        checkOutput("sw_fwd_alu", wbWord(0, 32'h00000019, 0, 5'd28, 32'h0));

        applyStimulus(exWord(1, 0, 1, 1, 5'd5, 32'h0, 32'h00000019));
        checkOutput("lw_19", wbWord(1, 32'h00000019, 1, 5'd5, 32'h08438433));

        // fwd=01: stores the WB load data at word 0x20
        applyStimulus(exWord(0, 1, 0, 0, 5'd5, 32'hdeadbeef, 32'h00000020));
        checkOutput("sw_fwd_mem", wbWord(0, 32'h00000020, 0, 5'd5, 32'h0));

        applyStimulus(exWord(1, 0, 1, 1, 5'd7, 32'h0, 32'h00000020));
        checkOutput("lw_20", wbWord(1, 32'h00000020, 1, 5'd7, 32'h08438433));

        applyStimulus(exWord(1, 0, 0, 0, 5'd0, 32'h0, 32'h00000055));
        checkOutput("alu_wr0", wbWord(0, 32'h00000055, 1, 5'd0, 32'h0));

        applyStimulus(exWord(0, 1, 0, 0, 5'd0, 32'hcafef00d, 32'h00000021));
        checkOutput("sw_wr0", wbWord(0, 32'h00000021, 0, 5'd0, 32'h0));

        applyStimulus(exWord(0, 0, 0, 0, 5'd9, 32'h0, 32'h00000077));
        checkOutput("alu_norw", wbWord(0, 32'h00000077, 0, 5'd9, 32'h0));

        applyStimulus(exWord(0, 1, 0, 0, 5'd9, 32'h12345678, 32'h00000022));
        checkOutput("sw_norw", wbWord(0, 32'h00000022, 0, 5'd9, 32'h0));

        applyStimulus(exWord(1, 0, 1, 1, 5'd3, 32'h0, 32'h00000021));
        checkOutput("lw_21", wbWord(1, 32'h00000021, 1, 5'd3, 32'hcafef00d));

        applyStimulus(exWord(1, 0, 1, 1, 5'd3, 32'h0, 32'h00000022));
        checkOutput("lw_22", wbWord(1, 32'h00000022, 1, 5'd3, 32'h12345678));

        applyStimulus(exWord(1, 0, 1, 1, 5'd4, 32'h0, 32'h00000419));
        checkOutput("lw_alias", wbWord(1, 32'h00000419, 1, 5'd4, 32'h08438433));

        applyStimulus(exWord(0, 0, 0, 0, 5'd4, 32'h0, 32'h00000419));
        checkOutput("noread", wbWord(0, 32'h00000419, 0, 5'd4, 32'h0));

        // Read and write of the same word: old data returned, new data kept
        applyStimulus(exWord(1, 1, 1, 1, 5'd31, 32'ha5a5a5a5, 32'h00000019));
        checkOutput("rw_same", wbWord(1, 32'h00000019, 1, 5'd31, 32'h08438433));

        applyStimulus(exWord(1, 0, 1, 1, 5'd2, 32'h0, 32'h00000019));
        checkOutput("lw_after_rw", wbWord(1, 32'h00000019, 1, 5'd2, 32'ha5a5a5a5));

        applyStimulus(exWord(0, 1, 0, 0, 5'd4, 32'h22222222, 32'h00000030));
        checkOutput("sw_30", wbWord(0, 32'h00000030, 0, 5'd4, 32'h0));

        ex_mem_reg = exWord(0, 1, 0, 0, 5'd6, 32'h11111111, 32'h00000030);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_mid", '0);
        @(posedge clk);
        #1 checkOutput("reset_hold", '0);
        rst_n = 1'b1;

        applyStimulus(exWord(1, 0, 1, 1, 5'd8, 32'h0, 32'h00000030));
        checkOutput("lw_30", wbWord(1, 32'h00000030, 1, 5'd8, 32'h22222222));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
